// File: rtl/fc_vector_serializer.sv
// Parallel-to-serial adapter between FC layers: captures an N-word vector on load
// and replays it one signed word per cycle with ena/out_ready handshake. Optional macro: RELU_EN.
module fc_vector_serializer #(
  parameter int N  = 84,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*DW-1:0]      vec_in,
  input  logic                 load,
  input  logic                 out_ready,
  output logic signed [DW-1:0] dout,
  output logic                 ena,
  output logic                 last,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_p0;
  state_t               state_nxt;
  logic [N*DW-1:0]      shift_p0;
  logic [IDX_W-1:0]     idx_p0;
  logic                 done_p1;
  logic                 overrun_p0;
  logic                 vld_p0;
  logic signed [DW-1:0] head_p0;
  logic                 xfer;
  logic                 final_xfer;
  logic                 accept;

`ifdef RELU_EN
  function automatic logic signed [DW-1:0] relu_clamp(input logic signed [DW-1:0] w);
    return w[DW-1] ? '0 : w;
  endfunction
`endif

  // Handshake decode shared by the FSM and the datapath
  assign vld_p0     = (state_p0 == SEND);
  assign xfer       = vld_p0 & out_ready;
  assign final_xfer = xfer & (idx_p0 == IDX_LAST);
  assign accept     = load & ((state_p0 == IDLE) | final_xfer);
  assign head_p0    = shift_p0[N*DW-1 -: DW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE: if (load) state_nxt = SEND;
      SEND: if (final_xfer && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ena  = vld_p0;
    busy = vld_p0;
    last = vld_p0 & (idx_p0 == IDX_LAST);
    done = done_p1;
    overrun = overrun_p0;
`ifdef RELU_EN
    dout = relu_clamp(head_p0);
`else
    dout = head_p0;
`endif
  end

  // p0: capture / shift stage; idx wraps to 0 after the last word so it stays below N
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_p0 <= '0;
      idx_p0   <= '0;
    end else if (accept) begin
      shift_p0 <= vec_in;
      idx_p0   <= '0;
    end else if (final_xfer) begin
      shift_p0 <= shift_p0 << DW;
      idx_p0   <= '0;
    end else if (xfer) begin
      shift_p0 <= shift_p0 << DW;
      idx_p0   <= idx_p0 + IDX_W'(1);
    end
  end

  // p1: completion pulse and sticky dropped-load flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_p1    <= 1'b0;
      overrun_p0 <= 1'b0;
    end else begin
      done_p1 <= final_xfer;
      if (load && vld_p0 && !final_xfer) overrun_p0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_vector_serializer.sv
// Directed bench for fc_vector_serializer: streaming, backpressure, dropped load,
// back-to-back vectors, async reset, and the RELU_EN sign handling.
module tb_fc_vector_serializer;
  localparam int N  = 84;
  localparam int DW = 16;
  localparam int VW = N * DW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [VW-1:0]        vec_in = '0;
  logic                 load = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] dout;
  logic [DW-1:0]        dout_u;
  logic                 ena, last, busy, done, overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          ld;
    logic          rdy;
    logic          e_ena;
    logic [DW-1:0] e_dout;
    logic          e_busy;
  } vec_t;

  always #5 clk = ~clk;
  assign dout_u = dout;

  fc_vector_serializer #(.N(N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .vec_in(vec_in), .load(load), .out_ready(out_ready),
    .dout(dout), .ena(ena), .last(last), .busy(busy), .done(done), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] mkvec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[(N-k)*DW-1 -: DW] = DW'(base + k);
    return v;
  endfunction

  initial begin
    vec_t          tbl[4];
    logic [VW-1:0] v6;
    logic [DW-1:0] w0;
    int            exp_k, dones, xfers;
    logic          will_xfer;

    // reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_ena", ena, 0);   chk("rst_dout", dout_u, 0); chk("rst_last", last, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);   chk("rst_ovr", overrun, 0);

    // 1: full vector with out_ready=1
    vec_in = mkvec(1); load = 1'b1; out_ready = 1'b1;
    tick(); load = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t1_ena[%0d]", k), ena, 1);
      chk($sformatf("t1_dout[%0d]", k), dout_u, k + 1);
      chk($sformatf("t1_last[%0d]", k), last, (k == N - 1));
      chk($sformatf("t1_done[%0d]", k), done, 0);
      tick();
    end
    chk("t1_done_pulse", done, 1); chk("t1_ena_off", ena, 0); chk("t1_busy_off", busy, 0);
    tick();
    chk("t1_done_once", done, 0);

    // 2: out_ready toggling
    vec_in = mkvec(1); load = 1'b1; out_ready = 1'b0;
    tick(); load = 1'b0;
    exp_k = 0; dones = 0; xfers = 0;
    for (int cyc = 0; cyc < 400 && exp_k < N; cyc++) begin
      out_ready = (cyc % 2 == 0);
      chk($sformatf("t2_ena[%0d]", cyc), ena, 1);
      chk($sformatf("t2_dout[%0d]", cyc), dout_u, exp_k + 1);
      will_xfer = out_ready;
      tick();
      if (will_xfer) begin exp_k++; xfers++; end
      if (done) dones++;
    end
    chk("t2_xfers", xfers, N);
    out_ready = 1'b1;
    tick();
    if (done) dones++;
    chk("t2_dones", dones, 1); chk("t2_busy_off", busy, 0);

    // 3: load dropped while sending word 30
    chk("t3_ovr_before", overrun, 0);
    vec_in = mkvec(1); load = 1'b1;
    tick(); load = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t3_dout[%0d]", k), dout_u, k + 1);
      if (k == 29) begin vec_in = mkvec(100); load = 1'b1; end
      tick();
      load = 1'b0;
      if (k == 29) chk("t3_ovr_set", overrun, 1);
    end
    chk("t3_done", done, 1); chk("t3_ovr_at_done", overrun, 1);
    tick(); tick();
    chk("t3_ovr_sticky", overrun, 1); chk("t3_idle", busy, 0);

    // 5: async reset mid-cycle at word 40 (overrun still set from 3)
    vec_in = mkvec(1); load = 1'b1;
    tick(); load = 1'b0;
    for (int k = 0; k < 39; k++) tick();
    chk("t5_at40", dout_u, 40);
    #2 reset = 1'b1;
    #1;
    chk("t5_ena", ena, 0); chk("t5_dout", dout_u, 0);
    chk("t5_busy", busy, 0); chk("t5_ovr", overrun, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_post_ena[%0d]", i), ena, 0);
    end

    // 4: second vector loaded on the final transfer
    vec_in = mkvec(1); load = 1'b1; out_ready = 1'b1;
    tick(); load = 1'b0;
    dones = 0; xfers = 0;
    for (int c = 0; c < 2 * N; c++) begin
      chk($sformatf("t4_ena[%0d]", c), ena, 1);
      chk($sformatf("t4_dout[%0d]", c), dout_u, (c < N) ? c + 1 : 100 + c - N);
      if (ena && out_ready) xfers++;
      if (c == N - 1) begin vec_in = mkvec(100); load = 1'b1; end
      tick();
      load = 1'b0;
      if (c == N - 1) chk("t4_done_first", done, 1);
      if (done) dones++;
    end
    chk("t4_xfers", xfers, 2 * N); chk("t4_dones", dones, 2); chk("t4_ena_off", ena, 0);
    tick();

    // 6: sign handling on the head word
`ifdef RELU_EN
    w0 = 16'h0000;
`else
    w0 = 16'hFFFB;
`endif
    v6 = '0;
    v6[VW-1 -: DW]    = 16'hFFFB;
    v6[VW-DW-1 -: DW] = 16'h0007;
    tbl[0] = '{ld: 1'b1, rdy: 1'b0, e_ena: 1'b1, e_dout: w0,       e_busy: 1'b1};
    tbl[1] = '{ld: 1'b0, rdy: 1'b0, e_ena: 1'b1, e_dout: w0,       e_busy: 1'b1};
    tbl[2] = '{ld: 1'b0, rdy: 1'b1, e_ena: 1'b1, e_dout: 16'h0007, e_busy: 1'b1};
    tbl[3] = '{ld: 1'b0, rdy: 1'b1, e_ena: 1'b1, e_dout: 16'h0000, e_busy: 1'b1};
    vec_in = v6;
    for (int i = 0; i < 4; i++) begin
      load = tbl[i].ld; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("t6_ena[%0d]", i), ena, tbl[i].e_ena);
      chk($sformatf("t6_dout[%0d]", i), dout_u, tbl[i].e_dout);
      chk($sformatf("t6_busy[%0d]", i), busy, tbl[i].e_busy);
    end
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
